spart_echo_driver: RTL

Parametrised successor to the fixed-rate SPART echo driver. It programs the SPART divisor from a compile-time clock frequency and the `br_cfg` switches, and reprograms it whenever `br_cfg` changes. Received bytes are buffered in a FIFO so bursts survive a busy transmitter, with optional ASCII case swap and an overrun counter. It sits between the board switches and the SPART bus interface in `mini_spart`.

---
 rtl/spart_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/spart_echo_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus addresses, FSM states and
// the baud-divisor helper used to build elaboration-time constants.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT_LO,
    ST_INIT_HI,
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  // DIV = clk_freq / (16 * baud) - 1, truncating division.
  function automatic logic [15:0] spart_div(input int unsigned clk_freq,
                                            input int unsigned baud);
    int unsigned div;
    div = clk_freq / (16 * baud) - 1;
    return div[15:0];
  endfunction

  // Swaps the case of ASCII letters; every other byte passes through.
  function automatic logic [7:0] ascii_case_swap(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if ((b >= 8'h61) && (b <= 8'h7A)) r = b - 8'h20;
    else if ((b >= 8'h41) && (b <= 8'h5A)) r = b + 8'h20;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// The head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/spart_echo_driver.sv
// Programs the SPART baud divisor from br_cfg and echoes received bytes back
// through a FIFO, with optional ASCII case swap and an overrun counter.
module spart_echo_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          case_swap,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [7:0]                    overrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [15:0] DIV_4800  = spart_div(CLK_FREQ, 4800);
  localparam logic [15:0] DIV_9600  = spart_div(CLK_FREQ, 9600);
  localparam logic [15:0] DIV_19200 = spart_div(CLK_FREQ, 19200);
  localparam logic [15:0] DIV_38400 = spart_div(CLK_FREQ, 38400);

  state_t      state_q;
  logic [1:0]  cfg_q;
  logic [7:0]  overrun_q;
  logic [15:0] div_sel;
  logic [7:0]  push_data_d;
  logic        drive_en;
  logic [7:0]  drive_data;
  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  always_comb begin
    div_sel = DIV_4800;
    unique case (cfg_q)
      2'b00: div_sel = DIV_4800;
      2'b01: div_sel = DIV_9600;
      2'b10: div_sel = DIV_19200;
      2'b11: div_sel = DIV_38400;
      default: div_sel = DIV_4800;
    endcase
  end

  assign push_data_d = case_swap ? ascii_case_swap(databus) : databus;
  assign fifo_push   = (state_q == ST_READ) && !fifo_full;
  assign fifo_pop    = (state_q == ST_WRITE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_data_d),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT_LO;
      cfg_q     <= br_cfg;
      overrun_q <= 8'h00;
    end else begin
      unique case (state_q)
        ST_INIT_LO: state_q <= ST_INIT_HI;
        ST_INIT_HI: state_q <= ST_IDLE;
        ST_IDLE: begin
          // A rate change outranks traffic; rda outranks tbr.
          if (br_cfg != cfg_q) begin
            cfg_q   <= br_cfg;
            state_q <= ST_INIT_LO;
          end else if (rda) begin
            state_q <= ST_READ;
          end else if (tbr && !fifo_empty) begin
            state_q <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (fifo_full && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'h01;
          state_q <= ST_IDLE;
        end
        ST_WRITE: state_q <= ST_IDLE;
        default:  state_q <= ST_INIT_LO;
      endcase
    end
  end

  // While rst is held the bus shows its quiet values regardless of state.
  always_comb begin
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = ADDR_BUF;
    drive_en   = 1'b0;
    drive_data = 8'h00;
    if (!rst) begin
      unique case (state_q)
        ST_INIT_LO: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = ADDR_DBL;
          drive_en   = 1'b1;
          drive_data = div_sel[7:0];
        end
        ST_INIT_HI: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = ADDR_DBH;
          drive_en   = 1'b1;
          drive_data = div_sel[15:8];
        end
        ST_READ: begin
          iocs   = 1'b1;
          iorw   = 1'b1;
          ioaddr = ADDR_BUF;
        end
        ST_WRITE: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = ADDR_BUF;
          drive_en   = 1'b1;
          drive_data = fifo_dout;
        end
        default: ;
      endcase
    end
  end

  assign databus     = drive_en ? drive_data : 8'hzz;
  assign overrun_cnt = overrun_q;

endmodule
